// File: rtl/task_13_pkg.sv
// Shared definitions for the task_13 input/output stage pair: default
// geometry and the output-stage state encoding.
package task_13_pkg;

    localparam int unsigned DATA_WIDTH_DEF = 8;
    localparam int unsigned NUM_WORDS_DEF  = 243;

    typedef enum logic [1:0] {
        s_IDLE,
        s_COLLECT,
        s_SEND,
        s_DONE
    } task_output_enum;

endpackage

// File: rtl/task_13_out_buf.sv
// Frame buffer for task_13_out: NUM_WORDS x DATA_WIDTH register array with
// one write port and one registered read port (1-cycle latency). The read
// register only updates on i_rd_en, so it doubles as the output data holder.
module task_13_out_buf #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned NUM_WORDS  = 243,
    parameter int unsigned CNT_WIDTH  = $clog2(NUM_WORDS + 1)
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_wr_en,
    input  logic [CNT_WIDTH-1:0]  i_wr_addr,
    input  logic [DATA_WIDTH-1:0] i_wr_data,
    input  logic                  i_rd_en,
    input  logic [CNT_WIDTH-1:0]  i_rd_addr,
    output logic [DATA_WIDTH-1:0] o_rd_data
);

    logic [DATA_WIDTH-1:0] mem_q [NUM_WORDS];
    logic [DATA_WIDTH-1:0] rd_data_q;

    // Storage array; contents are don't-care after reset.
    always_ff @(posedge i_clk) begin
        if (i_wr_en) begin
            mem_q[i_wr_addr] <= i_wr_data;
        end
    end

    // Synchronous read; holds its value while i_rd_en is low.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            rd_data_q <= '0;
        end else if (i_rd_en) begin
            rd_data_q <= mem_q[i_rd_addr];
        end
    end

    assign o_rd_data = rd_data_q;

endmodule

// File: rtl/task_13_out.sv
// task_13 output stage: captures one frame from the input stage, replays it
// in reverse arrival order on an AXI-Stream master and pulses o_output_last
// once the final beat has been accepted.
// Optional: define TASK_13_OUT_CHECKSUM_EN to append a beat carrying the
// mod-2^DATA_WIDTH sum of the captured words (tlast moves onto that beat).
module task_13_out
    import task_13_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int unsigned NUM_WORDS  = NUM_WORDS_DEF,
    parameter int unsigned CNT_WIDTH  = $clog2(NUM_WORDS + 1)
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic [DATA_WIDTH-1:0] i_data,
    input  logic                  i_enb,
    output logic [DATA_WIDTH-1:0] o_tdata,
    output logic                  o_tvalid,
    output logic                  o_tlast,
    input  logic                  i_tready,
    output logic                  o_output_last,
    output logic                  o_busy,
    output logic                  o_overflow
);

    localparam logic [CNT_WIDTH-1:0] ONE     = CNT_WIDTH'(1);
    localparam logic [CNT_WIDTH-1:0] MAX_CNT = CNT_WIDTH'(NUM_WORDS);

    task_output_enum state_q, state_d;

    logic [CNT_WIDTH-1:0]  count_q, count_d;
    logic [CNT_WIDTH-1:0]  rd_ptr_q, rd_ptr_d;
    logic                  tvalid_q, tvalid_d;
    logic                  tlast_q, tlast_d;
    logic                  overflow_q, overflow_d;
    logic [CNT_WIDTH-1:0]  count_inc;
    logic                  last_hs;
    logic                  load;

    logic                  wr_en;
    logic [CNT_WIDTH-1:0]  wr_addr;
    logic                  rd_en;
    logic [DATA_WIDTH-1:0] rd_data;

`ifdef TASK_13_OUT_CHECKSUM_EN
    logic [DATA_WIDTH-1:0] sum_q, sum_d;
    logic                  sum_sel_q, sum_sel_d;
    logic                  words_done_q, words_done_d;
`endif

    assign count_inc = count_q + ONE;
    // Final beat of the frame is being accepted this cycle.
    assign last_hs   = tvalid_q && i_tready && tlast_q;
    // Output register may take a new beat.
    assign load      = !tvalid_q || i_tready;

    task_13_out_buf #(
        .DATA_WIDTH (DATA_WIDTH),
        .NUM_WORDS  (NUM_WORDS),
        .CNT_WIDTH  (CNT_WIDTH)
    ) u_buf (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_wr_en   (wr_en),
        .i_wr_addr (wr_addr),
        .i_wr_data (i_data),
        .i_rd_en   (rd_en),
        .i_rd_addr (rd_ptr_q),
        .o_rd_data (rd_data)
    );

    // State register.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= s_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: collect until full or a gap, send, then one done cycle.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            s_IDLE: begin
                if (i_enb) begin
                    state_d = (MAX_CNT == ONE) ? s_SEND : s_COLLECT;
                end
            end
            s_COLLECT: begin
                if (!i_enb || count_inc == MAX_CNT) begin
                    state_d = s_SEND;
                end
            end
            s_SEND: begin
                if (last_hs) begin
                    state_d = s_DONE;
                end
            end
            s_DONE:  state_d = s_IDLE;
            default: state_d = s_IDLE;
        endcase
    end

    // Datapath registers: counters, output beat flags, sticky overflow.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            count_q      <= '0;
            rd_ptr_q     <= '0;
            tvalid_q     <= 1'b0;
            tlast_q      <= 1'b0;
            overflow_q   <= 1'b0;
`ifdef TASK_13_OUT_CHECKSUM_EN
            sum_q        <= '0;
            sum_sel_q    <= 1'b0;
            words_done_q <= 1'b0;
`endif
        end else begin
            count_q      <= count_d;
            rd_ptr_q     <= rd_ptr_d;
            tvalid_q     <= tvalid_d;
            tlast_q      <= tlast_d;
            overflow_q   <= overflow_d;
`ifdef TASK_13_OUT_CHECKSUM_EN
            sum_q        <= sum_d;
            sum_sel_q    <= sum_sel_d;
            words_done_q <= words_done_d;
`endif
        end
    end

    // Datapath next-state: buffer writes while collecting, reverse reads while
    // sending. rd_ptr tracks count-1 during collection so it is ready on entry.
    always_comb begin
        count_d      = count_q;
        rd_ptr_d     = rd_ptr_q;
        tvalid_d     = tvalid_q;
        tlast_d      = tlast_q;
        overflow_d   = overflow_q;
        wr_en        = 1'b0;
        wr_addr      = count_q;
        rd_en        = 1'b0;
`ifdef TASK_13_OUT_CHECKSUM_EN
        sum_d        = sum_q;
        sum_sel_d    = sum_sel_q;
        words_done_d = words_done_q;
`endif
        case (state_q)
            s_IDLE: begin
                if (i_enb) begin
                    wr_en    = 1'b1;
                    wr_addr  = '0;
                    count_d  = ONE;
                    rd_ptr_d = '0;
`ifdef TASK_13_OUT_CHECKSUM_EN
                    sum_d    = sum_q + i_data;
`endif
                end
            end
            s_COLLECT: begin
                if (i_enb) begin
                    wr_en    = 1'b1;
                    count_d  = count_inc;
                    rd_ptr_d = count_q;
`ifdef TASK_13_OUT_CHECKSUM_EN
                    sum_d    = sum_q + i_data;
`endif
                end
            end
            s_SEND: begin
                if (i_enb) begin
                    overflow_d = 1'b1;
                end
                if (last_hs) begin
                    tvalid_d = 1'b0;
                    tlast_d  = 1'b0;
                end else if (load) begin
                    tvalid_d = 1'b1;
`ifdef TASK_13_OUT_CHECKSUM_EN
                    if (words_done_q) begin
                        tlast_d   = 1'b1;
                        sum_sel_d = 1'b1;
                    end else begin
                        rd_en     = 1'b1;
                        tlast_d   = 1'b0;
                        sum_sel_d = 1'b0;
                        if (rd_ptr_q == '0) begin
                            words_done_d = 1'b1;
                        end else begin
                            rd_ptr_d = rd_ptr_q - ONE;
                        end
                    end
`else
                    rd_en   = 1'b1;
                    tlast_d = (rd_ptr_q == '0);
                    if (rd_ptr_q != '0) begin
                        rd_ptr_d = rd_ptr_q - ONE;
                    end
`endif
                end
            end
            s_DONE: begin
                if (i_enb) begin
                    overflow_d = 1'b1;
                end
                count_d      = '0;
                rd_ptr_d     = '0;
`ifdef TASK_13_OUT_CHECKSUM_EN
                sum_d        = '0;
                sum_sel_d    = 1'b0;
                words_done_d = 1'b0;
`endif
            end
            default: ;
        endcase
    end

    // Outputs decoded from registered state and beat registers.
    always_comb begin
        o_busy        = (state_q != s_IDLE);
        o_output_last = (state_q == s_DONE);
        o_tvalid      = tvalid_q;
        o_tlast       = tlast_q;
        o_overflow    = overflow_q;
`ifdef TASK_13_OUT_CHECKSUM_EN
        o_tdata       = sum_sel_q ? sum_q : rd_data;
`else
        o_tdata       = rd_data;
`endif
    end

endmodule

// File: tb/tb_task_13_out.sv
// Self-checking bench for task_13_out: a driver issues frames and pushes the
// expected reversed beats into a queue; a monitor pops and compares on every
// accepted beat and checks stall stability and the done pulse.
module tb_task_13_out;

    localparam int NW = 243;

    logic       i_clk = 1'b0;
    logic       i_rst;
    logic [7:0] i_data;
    logic       i_enb;
    logic [7:0] o_tdata;
    logic       o_tvalid;
    logic       o_tlast;
    logic       i_tready;
    logic       o_output_last;
    logic       o_busy;
    logic       o_overflow;

    typedef struct packed {
        logic [7:0] data;
        logic       last;
    } beat_t;

    int         errors = 0;
    int         checks = 0;
    beat_t      exp_q[$];
    logic [7:0] stim [0:299];
    int         beats_seen = 0;
    int         ready_mode = 0;
    bit         exp_overflow = 1'b0;

    always #5 i_clk = ~i_clk;

    task_13_out dut (
        .i_clk         (i_clk),
        .i_rst         (i_rst),
        .i_data        (i_data),
        .i_enb         (i_enb),
        .o_tdata       (o_tdata),
        .o_tvalid      (o_tvalid),
        .o_tlast       (o_tlast),
        .i_tready      (i_tready),
        .o_output_last (o_output_last),
        .o_busy        (o_busy),
        .o_overflow    (o_overflow)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Sink ready: 0 = always, 1 = random, 2 = repeating 1,0,0.
    initial begin
        int tog;
        tog = 0;
        i_tready = 1'b1;
        forever begin
            @(posedge i_clk);
            #1;
            case (ready_mode)
                1: i_tready = 1'($urandom_range(0, 1));
                2: begin
                    i_tready = (tog == 0);
                    tog = (tog + 1) % 3;
                end
                default: i_tready = 1'b1;
            endcase
        end
    end

    // Monitor / scoreboard.
    bit    ol_pending = 1'b0;
    bit    busy_chk = 1'b0;
    bit    stall_chk = 1'b0;
    bit    prev_nonlast = 1'b0;
    beat_t stall_beat;
    always @(negedge i_clk) begin
        beat_t e;
        if (i_rst) begin
            exp_q.delete();
            ol_pending   = 1'b0;
            busy_chk     = 1'b0;
            stall_chk    = 1'b0;
            prev_nonlast = 1'b0;
        end else begin
            if (busy_chk) check("busy_after_done", 32'(o_busy), 32'd0);
            busy_chk = o_output_last;
            if (ol_pending || o_output_last) begin
                check("output_last", 32'(o_output_last), 32'(ol_pending));
            end
            ol_pending = 1'b0;
            if (stall_chk) begin
                check("stall_valid", 32'(o_tvalid), 32'd1);
                check("stall_hold", 32'({o_tdata, o_tlast}), 32'(stall_beat));
            end
            if (prev_nonlast && ready_mode == 0) check("no_bubble", 32'(o_tvalid), 32'd1);
            stall_chk    = 1'b0;
            prev_nonlast = 1'b0;
            if (o_tvalid && i_tready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_beat", 32'(o_tvalid), 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("beat", 32'({o_tdata, o_tlast}), 32'(e));
                    beats_seen++;
                    ol_pending   = e.last;
                    prev_nonlast = !e.last;
                end
            end else if (o_tvalid) begin
                stall_chk  = 1'b1;
                stall_beat = {o_tdata, o_tlast};
            end
        end
    end

    // Drive n consecutive words from stim[], then predict the reversed replay.
    task automatic send_frame(input int n);
        logic [7:0] sum;
        beat_t      b;
        sum = '0;
        for (int i = 0; i < n; i++) begin
            i_enb  = 1'b1;
            i_data = stim[i];
            sum    = sum + stim[i];
            @(posedge i_clk);
            #1;
        end
        i_enb = 1'b0;
        for (int i = n - 1; i >= 0; i--) begin
            b.data = stim[i];
`ifdef TASK_13_OUT_CHECKSUM_EN
            b.last = 1'b0;
`else
            b.last = (i == 0);
`endif
            exp_q.push_back(b);
        end
`ifdef TASK_13_OUT_CHECKSUM_EN
        b.data = sum;
        b.last = 1'b1;
        exp_q.push_back(b);
`endif
    endtask

    // Wait (bounded) for the done pulse; returns at that cycle's negedge.
    task automatic wait_done(input string name);
        bit seen;
        seen = 1'b0;
        for (int k = 0; k < 3000 && !seen; k++) begin
            @(negedge i_clk);
            seen = o_output_last;
        end
        if (!seen) check({name, "_timeout"}, 32'(o_output_last), 32'd1);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge i_clk);
            #1;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int n;
        i_rst  = 1'b1;
        i_enb  = 1'b0;
        i_data = '0;
        repeat (3) @(posedge i_clk);
        #1;
        check("rst_tvalid", 32'(o_tvalid), 32'd0);
        check("rst_tlast", 32'(o_tlast), 32'd0);
        check("rst_output_last", 32'(o_output_last), 32'd0);
        check("rst_busy", 32'(o_busy), 32'd0);
        check("rst_overflow", 32'(o_overflow), 32'd0);
        check("rst_tdata", 32'(o_tdata), 32'd0);
        i_rst = 1'b0;
        idle(2);

        // Basic 3-word frame with fill-cycle latency.
        ready_mode = 0;
        stim[0] = 8'h01; stim[1] = 8'h02; stim[2] = 8'h03;
        send_frame(3);
        idle(1);
        check("fill_tvalid", 32'(o_tvalid), 32'd0);
        check("fill_busy", 32'(o_busy), 32'd1);
        idle(1);
        check("first_tvalid", 32'(o_tvalid), 32'd1);
        check("first_tdata", 32'(o_tdata), 32'h03);
        wait_done("basic");
        idle(3);

        // Stalling sink.
        ready_mode = 2;
        send_frame(3);
        wait_done("stall");
        ready_mode = 0;
        idle(2);

        // Back-to-back frames, second starting the cycle after the done pulse.
        for (int i = 0; i < 4; i++) stim[i] = 8'($urandom);
        send_frame(4);
        wait_done("b2b_a");
        @(posedge i_clk);
        #1;
        for (int i = 0; i < 3; i++) stim[i] = 8'($urandom);
        send_frame(3);
        wait_done("b2b_b");
        check("b2b_overflow", 32'(o_overflow), 32'(exp_overflow));
        idle(2);

        // Checksum-sensitive frame.
        stim[0] = 8'h80; stim[1] = 8'h90;
        send_frame(2);
        wait_done("csum");
        idle(2);

        // Random frames with random sink behaviour.
        for (int f = 0; f < 10; f++) begin
            n = (f == 0) ? 1 : int'($urandom_range(1, 24));
            for (int i = 0; i < n; i++) stim[i] = 8'($urandom);
            ready_mode = int'($urandom_range(0, 2));
            send_frame(n);
            wait_done("rand");
            ready_mode = 0;
            idle(int'($urandom_range(1, 4)));
        end
        check("rand_overflow", 32'(o_overflow), 32'(exp_overflow));
        check("rand_queue_empty", 32'(exp_q.size()), 32'd0);

        // Reset after two beats of a 5-word frame.
        for (int i = 0; i < 5; i++) stim[i] = 8'(8'h11 * (i + 1));
        base = beats_seen;
        send_frame(5);
        for (int k = 0; k < 100 && beats_seen < base + 2; k++) @(negedge i_clk);
        check("abort_two_beats", 32'(beats_seen - base), 32'd2);
        @(posedge i_clk);
        #1;
        i_rst = 1'b1;
        @(posedge i_clk);
        #1;
        i_rst = 1'b0;
        check("abort_tvalid", 32'(o_tvalid), 32'd0);
        check("abort_tlast", 32'(o_tlast), 32'd0);
        check("abort_output_last", 32'(o_output_last), 32'd0);
        check("abort_busy", 32'(o_busy), 32'd0);
        check("abort_tdata", 32'(o_tdata), 32'd0);
        idle(5);
        stim[0] = 8'hAA; stim[1] = 8'hBB;
        send_frame(2);
        wait_done("after_abort");
        idle(2);

        // Full frame plus one dropped word.
        for (int i = 0; i < NW; i++) stim[i] = 8'(i);
        send_frame(NW);
        check("full_busy", 32'(o_busy), 32'd1);
        i_enb  = 1'b1;
        i_data = 8'hEE;
        @(posedge i_clk);
        #1;
        i_enb = 1'b0;
        exp_overflow = 1'b1;
        check("overflow_set", 32'(o_overflow), 32'(exp_overflow));
        wait_done("full");
        idle(3);
        check("overflow_sticky", 32'(o_overflow), 32'(exp_overflow));
        check("final_queue_empty", 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/task_13_out.md
Name: task_13_out

Overview:
- Output stage paired with the task_13 input stage.
- Consumes the word stream the input stage drains from its FIFO (data plus per-word enable strobe) and captures one frame into a local buffer.
- Replays the frame in reverse arrival order on an AXI-Stream master port.
- Pulses o_output_last back to the input stage so it can request the next packet.

Parameters:
DATA_WIDTH, 8, width of input words and output tdata.
NUM_WORDS, 243, buffer depth and maximum frame length in words.
CNT_WIDTH, $clog2(NUM_WORDS+1), width of the word counter and pointers.

Ports:
i_clk  input  1  single clock; all logic on posedge.
i_rst  input  1  synchronous, active-high reset.
i_data  input  DATA_WIDTH  word from input stage.
i_enb  input  1  i_data is valid this cycle; no back-pressure toward the input stage.
o_tdata  output  DATA_WIDTH  AXI-Stream data.
o_tvalid  output  1  AXI-Stream valid.
o_tlast  output  1  marks the final beat of the frame.
i_tready  input  1  AXI-Stream ready from the sink.
o_output_last  output  1  one-cycle pulse after the last beat is accepted.
o_busy  output  1  high in any state except s_IDLE.
o_overflow  output  1  sticky; a word was dropped; cleared only by i_rst.

Behaviour:
- Reset (i_rst high at a posedge):
  - state = s_IDLE; counters and pointers = 0.
  - o_tvalid, o_tlast, o_output_last, o_busy, o_overflow = 0; o_tdata = 0.
  - Buffer contents are don't-care.
  - Reset mid-frame aborts the frame; no o_output_last is emitted.
- States: s_IDLE, s_COLLECT, s_SEND, s_DONE.
- s_IDLE:
  - i_enb = 1: write i_data to buf[0], count = 1, go to s_COLLECT.
  - If NUM_WORDS = 1, go directly to s_SEND.
- s_COLLECT, i_enb = 1: write buf[count], count++.
  - The word that makes count == NUM_WORDS is written, then go to s_SEND.
- s_COLLECT, i_enb = 0: the gap ends the frame; go to s_SEND with the current count (count ≥ 1 is guaranteed).
- s_SEND:
  - Read pointer starts at count-1 and decrements to 0 (reverse order).
  - o_tdata, o_tvalid and o_tlast are registered and reloaded when (!o_tvalid || i_tready).
  - First o_tvalid is asserted 1 cycle after entering s_SEND.
  - o_tdata and o_tlast stay stable while o_tvalid && !i_tready.
  - o_tlast = 1 on the beat carrying buf[0].
  - Handshake on the tlast beat (o_tvalid & i_tready & o_tlast): next cycle o_tvalid = 0, go to s_DONE.
- s_DONE: o_output_last = 1 for exactly this cycle; count = 0; go to s_IDLE.
- i_enb = 1 in s_SEND or s_DONE: word is dropped and o_overflow is set.
  - Words past NUM_WORDS are therefore dropped as well.
- Back-to-back frames: a word arriving in the first s_IDLE cycle after s_DONE starts a new frame with no bubble required.
- Throughput: 1 beat/cycle while i_tready is held high. Frame of N words occupies the output for N cycles plus 1 fill cycle.
- Arithmetic: counters are unsigned CNT_WIDTH. The read pointer never wraps below 0; s_SEND exits on the buf[0] beat.

Optional Feature:
- Macro: TASK_13_OUT_CHECKSUM_EN.
- Defined:
  - An 8-bit-wide (DATA_WIDTH) running sum, mod 2^DATA_WIDTH, of all captured words is accumulated in s_COLLECT/s_IDLE writes and cleared in s_DONE.
  - After the buf[0] beat, one extra beat carries the sum, with o_tlast on that beat instead of on buf[0].
  - o_output_last follows that beat's handshake.
- Undefined: no checksum logic; frame length on the output equals the captured count.

Decomposition:
- Package task_13_pkg holds:
  - the state enum typedef task_output_enum {s_IDLE, s_COLLECT, s_SEND, s_DONE};
  - the defaults for DATA_WIDTH and NUM_WORDS, shared with the input stage.
- One sub-module, task_13_out_buf:
  - simple dual-port register buffer, NUM_WORDS x DATA_WIDTH;
  - one write port, one synchronous read port with 1-cycle latency;
  - the FSM drives it from the top level.

Test Plan:
- Frame 0x01,0x02,0x03 on consecutive i_enb cycles, then gap, i_tready = 1 -> tdata 0x03,0x02,0x01 on consecutive cycles, tlast on 0x01, o_output_last one cycle after that beat, o_busy low the cycle after.
- 243 consecutive words 0..242 with no gap -> s_SEND entered after word 242; 243 beats 242..0; a 244th word sent at that time sets o_overflow and is not output.
- Same 3-word frame with i_tready toggling 1,0,0,1,... -> o_tdata/o_tlast hold during stalls; output order unchanged; no beat duplicated or lost.
- i_rst pulsed after 2 beats of a 5-word frame -> all outputs 0 the next cycle, no o_output_last; a following 2-word frame 0xAA,0xBB outputs 0xBB,0xAA.
- Two frames, the second starting the cycle after o_output_last -> both replayed correctly reversed, o_overflow stays 0.
- With TASK_13_OUT_CHECKSUM_EN, frame 0x80,0x90 -> beats 0x90,0x80,0x10 with tlast only on 0x10; without the macro -> 0x90,0x80, tlast on 0x80.
